// File: rtl/handball_pkg.sv
// handball_pkg -- shared definitions for the handball referee.
//
// Contents:
//   state_e         referee FSM encoding (IDLE, PLAY, WINDOW, SERVE, OVER)
//   BALL_AT_PADDLE  LGOUT pattern meaning the ball sits at the paddle end
//   RALLY_W/MISS_W  widths of the rally and miss counters
//   RALLY_MAX       saturation value of the rally counter
//   multi_hot()     true when more than one bit of a ball-position word is set
package handball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_WINDOW = 3'd2,
        ST_SERVE  = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam logic [7:0] BALL_AT_PADDLE = 8'h80;

    localparam int RALLY_W = 8;
    localparam int MISS_W  = 4;

    localparam logic [RALLY_W-1:0] RALLY_MAX = '1;

    // Clearing the lowest set bit leaves something only if a second bit was set.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/paddle_edge.sv
// paddle_edge -- conditions the asynchronous paddle button.
//
// Two-flop synchronizer, optional debounce filter, then rising-edge detect.
// The debounce filter is built only when REFEREE_DEBOUNCE_EN is defined; it
// accepts a new level after DEBOUNCE_CYCLES consecutive equal synchronized
// samples. Without the macro the synchronized value feeds the edge detector
// directly.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   pulser_async  in   raw paddle button level
//   rise_pulse    out  one-cycle pulse on each accepted rising edge
//                      (combinational from flops, valid the cycle after the
//                      synchronized level turns high)
module paddle_edge #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pulser_async,
    output logic rise_pulse
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cfg
        $error("paddle_edge: DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic filt;

    always_comb begin
        sync1_d = pulser_async;
        sync2_d = sync1_q;
        prev_d  = filt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef REFEREE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // cnt_q counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign filt = deb_q;
`else
    assign filt = sync2_q;
`endif

    assign rise_pulse = filt & ~prev_q;

endmodule

// File: rtl/handball_referee.sv
// handball_referee -- scores a one-player handball game.
//
// Watches the ball-position bus and the paddle button, decides returns,
// misses and fouls, and keeps rally / miss counts. Build option:
// REFEREE_DEBOUNCE_EN adds a DEBOUNCE_CYCLES debounce filter on the paddle.
//
// Ports:
//   CLKK       in   system clock
//   RESET      in   synchronous active-high reset
//   START      in   new game / serve request (level)
//   PULSER     in   paddle button, asynchronous level
//   LGOUT[7:0] in   ball position, bit7 = paddle end, bit0 = wall
//   HIT        out  one-cycle pulse, valid return
//   MISS       out  one-cycle pulse, ball left the paddle end unreturned
//   FOUL       out  one-cycle pulse, paddle pressed in PLAY
//   RALLY[7:0] out  consecutive hits this serve, saturating at 255
//   MISS_CNT   out  misses this game
//   SERVE_REQ  out  waiting for START after a miss
//   GAME_OVER  out  MISS_CNT reached MAX_MISSES
//   POS_ERR    out  sticky, LGOUT ever had more than one bit set
//
// HIT/FOUL appear three cycles after a PULSER rising edge: two synchronizer
// flops plus the registered outputs. The FSM state is held in state_q.
module handball_referee
    import handball_pkg::*;
#(
    parameter int MAX_MISSES      = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               CLKK,
    input  logic               RESET,
    input  logic               START,
    input  logic               PULSER,
    input  logic [7:0]         LGOUT,
    output logic               HIT,
    output logic               MISS,
    output logic               FOUL,
    output logic [RALLY_W-1:0] RALLY,
    output logic [MISS_W-1:0]  MISS_CNT,
    output logic               SERVE_REQ,
    output logic               GAME_OVER,
    output logic               POS_ERR
);

    if (MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_bad_miss_cfg
        $error("handball_referee: MAX_MISSES must be within 1..15");
    end

    logic paddle_rise;

    paddle_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_paddle_edge (
        .clk          (CLKK),
        .rst          (RESET),
        .pulser_async (PULSER),
        .rise_pulse   (paddle_rise)
    );

    state_e             state_q,    state_d;
    logic               armed_q,    armed_d;
    logic [RALLY_W-1:0] rally_q,    rally_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               hit_q,      hit_d;
    logic               miss_q,     miss_d;
    logic               foul_q,     foul_d;
    logic               pos_err_q,  pos_err_d;

    logic               at_paddle;
    logic [MISS_W-1:0]  miss_cnt_inc;

    always_comb begin
        at_paddle    = (LGOUT == BALL_AT_PADDLE);
        miss_cnt_inc = miss_cnt_q + 1'b1;

        state_d    = state_q;
        rally_d    = rally_q;
        miss_cnt_d = miss_cnt_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        foul_d     = 1'b0;
        pos_err_d  = pos_err_q | multi_hot(LGOUT);
        // Re-arm once the ball has moved off the paddle end, so one visit to
        // 8'h80 opens at most one window.
        armed_d    = at_paddle ? armed_q : 1'b1;

        // START is checked first in every state: it outranks paddle and ball.
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_PLAY;
                    rally_d    = '0;
                    miss_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                if (START) begin
                    rally_d = '0;
                end else if (paddle_rise) begin
                    foul_d = 1'b1;
                end else if (at_paddle && armed_q) begin
                    state_d = ST_WINDOW;
                    armed_d = 1'b0;
                end
            end
            ST_WINDOW: begin
                if (START) begin
                    state_d = ST_PLAY;
                    rally_d = '0;
                end else if (!at_paddle) begin
                    // Ball left the paddle end; a press in this same cycle
                    // is too late and still counts as a miss.
                    miss_d     = 1'b1;
                    miss_cnt_d = miss_cnt_inc;
                    rally_d    = '0;
                    state_d    = (miss_cnt_inc == MISS_W'(MAX_MISSES)) ? ST_OVER : ST_SERVE;
                end else if (paddle_rise) begin
                    hit_d   = 1'b1;
                    rally_d = (rally_q == RALLY_MAX) ? RALLY_MAX : rally_q + 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_SERVE: begin
                if (START) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (START) begin
                    state_d    = ST_PLAY;
                    rally_d    = '0;
                    miss_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            rally_q    <= '0;
            miss_cnt_q <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            foul_q     <= 1'b0;
            pos_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            rally_q    <= rally_d;
            miss_cnt_q <= miss_cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            foul_q     <= foul_d;
            pos_err_q  <= pos_err_d;
        end
    end

    assign HIT       = hit_q;
    assign MISS      = miss_q;
    assign FOUL      = foul_q;
    assign RALLY     = rally_q;
    assign MISS_CNT  = miss_cnt_q;
    assign SERVE_REQ = (state_q == ST_SERVE);
    assign GAME_OVER = (state_q == ST_OVER);
    assign POS_ERR   = pos_err_q;

endmodule

// File: tb/tb_handball_referee.sv
// tb_handball_referee -- directed self-checking bench for handball_referee
// (default build: MAX_MISSES = 3, no debounce filter).
module tb_handball_referee;

    logic       CLKK = 1'b0;
    logic       RESET;
    logic       START;
    logic       PULSER;
    logic [7:0] LGOUT;
    logic       HIT, MISS, FOUL;
    logic [7:0] RALLY;
    logic [3:0] MISS_CNT;
    logic       SERVE_REQ, GAME_OVER, POS_ERR;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int hit_seen  = 0;
    int miss_seen = 0;
    int foul_seen = 0;
    int excl_viol = 0;

    handball_referee #(
        .MAX_MISSES      (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLKK      (CLKK),
        .RESET     (RESET),
        .START     (START),
        .PULSER    (PULSER),
        .LGOUT     (LGOUT),
        .HIT       (HIT),
        .MISS      (MISS),
        .FOUL      (FOUL),
        .RALLY     (RALLY),
        .MISS_CNT  (MISS_CNT),
        .SERVE_REQ (SERVE_REQ),
        .GAME_OVER (GAME_OVER),
        .POS_ERR   (POS_ERR)
    );

    // Clock / reset block
    always #5 CLKK = ~CLKK;

    // Pulse tally, sampled 1 time unit after the active edge.
    always @(posedge CLKK) begin
        #1;
        hit_seen  += int'(HIT);
        miss_seen += int'(MISS);
        foul_seen += int'(FOUL);
        if (int'(HIT) + int'(MISS) + int'(FOUL) > 1) excl_viol++;
    end

    // Driver tasks (inputs change on the falling edge)
    task automatic tick(input int n);
        repeat (n) @(negedge CLKK);
    endtask

    task automatic clear_seen();
        hit_seen  = 0;
        miss_seen = 0;
        foul_seen = 0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    // Arm, open a window, press and hold through the HIT cycle.
    task automatic hit_window();
        PULSER = 1'b0;
        LGOUT  = 8'h40;
        tick(3);
        LGOUT  = 8'h80;
        tick(1);
        PULSER = 1'b1;
        tick(3);
        PULSER = 1'b0;
    endtask

    // Arm, open a window, let the ball leave unreturned.
    task automatic miss_window();
        LGOUT = 8'h40;
        tick(1);
        LGOUT = 8'h80;
        tick(1);
        LGOUT = 8'h40;
        tick(1);
    endtask

    task automatic test_reset();
        RESET  = 1'b1;
        START  = 1'b1;
        PULSER = 1'b0;
        LGOUT  = 8'h00;
        tick(2);
        total_cnt++; if (HIT !== 1'b0) $display("FAIL reset_hit: got %b want 0", HIT); else pass_cnt++;
        total_cnt++; if (MISS !== 1'b0) $display("FAIL reset_miss: got %b want 0", MISS); else pass_cnt++;
        total_cnt++; if (FOUL !== 1'b0) $display("FAIL reset_foul: got %b want 0", FOUL); else pass_cnt++;
        total_cnt++; if (RALLY !== 8'd0) $display("FAIL reset_rally: got %0d want 0", RALLY); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd0) $display("FAIL reset_miss_cnt: got %0d want 0", MISS_CNT); else pass_cnt++;
        total_cnt++; if (SERVE_REQ !== 1'b0) $display("FAIL reset_serve_req: got %b want 0", SERVE_REQ); else pass_cnt++;
        total_cnt++; if (GAME_OVER !== 1'b0) $display("FAIL reset_game_over: got %b want 0", GAME_OVER); else pass_cnt++;
        total_cnt++; if (POS_ERR !== 1'b0) $display("FAIL reset_pos_err: got %b want 0", POS_ERR); else pass_cnt++;
        START = 1'b0;
        RESET = 1'b0;
        tick(1);
    endtask

    task automatic test_hit();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            LGOUT = 8'h01 << i;
            tick(1);
        end
        clear_seen();
        PULSER = 1'b1;
        tick(2);
        total_cnt++; if (HIT !== 1'b0) $display("FAIL hit_too_early: got %b want 0", HIT); else pass_cnt++;
        tick(1);
        total_cnt++; if (HIT !== 1'b1) $display("FAIL hit_latency3: got %b want 1", HIT); else pass_cnt++;
        total_cnt++; if (RALLY !== 8'd1) $display("FAIL hit_rally: got %0d want 1", RALLY); else pass_cnt++;
        total_cnt++; if (FOUL !== 1'b0) $display("FAIL hit_foul: got %b want 0", FOUL); else pass_cnt++;
        tick(1);
        total_cnt++; if (HIT !== 1'b0) $display("FAIL hit_one_cycle: got %b want 0", HIT); else pass_cnt++;
        PULSER = 1'b0;
        tick(3);
        total_cnt++; if (hit_seen !== 1) $display("FAIL hit_count: got %0d want 1", hit_seen); else pass_cnt++;
        total_cnt++; if (foul_seen !== 0) $display("FAIL hit_foul_count: got %0d want 0", foul_seen); else pass_cnt++;
    endtask

    task automatic test_miss();
        clear_seen();
        miss_window();
        total_cnt++; if (MISS !== 1'b1) $display("FAIL miss_pulse: got %b want 1", MISS); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd1) $display("FAIL miss_cnt1: got %0d want 1", MISS_CNT); else pass_cnt++;
        total_cnt++; if (RALLY !== 8'd0) $display("FAIL miss_rally_clear: got %0d want 0", RALLY); else pass_cnt++;
        total_cnt++; if (SERVE_REQ !== 1'b1) $display("FAIL miss_serve_req: got %b want 1", SERVE_REQ); else pass_cnt++;
        tick(1);
        total_cnt++; if (MISS !== 1'b0) $display("FAIL miss_one_cycle: got %b want 0", MISS); else pass_cnt++;
        total_cnt++; if (miss_seen !== 1) $display("FAIL miss_count: got %0d want 1", miss_seen); else pass_cnt++;
        pulse_start();
        total_cnt++; if (SERVE_REQ !== 1'b0) $display("FAIL serve_req_clear: got %b want 0", SERVE_REQ); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd1) $display("FAIL serve_keeps_cnt: got %0d want 1", MISS_CNT); else pass_cnt++;
    endtask

    task automatic test_game_over();
        miss_window();
        total_cnt++; if (MISS_CNT !== 4'd2) $display("FAIL over_cnt2: got %0d want 2", MISS_CNT); else pass_cnt++;
        total_cnt++; if (GAME_OVER !== 1'b0) $display("FAIL over_early: got %b want 0", GAME_OVER); else pass_cnt++;
        pulse_start();
        miss_window();
        total_cnt++; if (GAME_OVER !== 1'b1) $display("FAIL over_set: got %b want 1", GAME_OVER); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd3) $display("FAIL over_cnt3: got %0d want 3", MISS_CNT); else pass_cnt++;
        total_cnt++; if (SERVE_REQ !== 1'b0) $display("FAIL over_serve_req: got %b want 0", SERVE_REQ); else pass_cnt++;
        clear_seen();
        LGOUT  = 8'h80;
        PULSER = 1'b1;
        tick(4);
        PULSER = 1'b0;
        tick(3);
        LGOUT  = 8'h08;
        PULSER = 1'b1;
        tick(4);
        PULSER = 1'b0;
        tick(3);
        total_cnt++; if (hit_seen + foul_seen !== 0) $display("FAIL over_ignores_paddle: got %0d pulses want 0", hit_seen + foul_seen); else pass_cnt++;
        total_cnt++; if (GAME_OVER !== 1'b1) $display("FAIL over_holds: got %b want 1", GAME_OVER); else pass_cnt++;
        pulse_start();
        total_cnt++; if (GAME_OVER !== 1'b0) $display("FAIL over_restart: got %b want 0", GAME_OVER); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd0) $display("FAIL over_cnt_clear: got %0d want 0", MISS_CNT); else pass_cnt++;
        total_cnt++; if (RALLY !== 8'd0) $display("FAIL over_rally_clear: got %0d want 0", RALLY); else pass_cnt++;
    endtask

    task automatic test_foul_and_coincident();
        hit_window();
        LGOUT = 8'h08;
        tick(3);
        clear_seen();
        PULSER = 1'b1;
        tick(3);
        total_cnt++; if (FOUL !== 1'b1) $display("FAIL foul_pulse: got %b want 1", FOUL); else pass_cnt++;
        total_cnt++; if (HIT !== 1'b0) $display("FAIL foul_no_hit: got %b want 0", HIT); else pass_cnt++;
        total_cnt++; if (RALLY !== 8'd1) $display("FAIL foul_rally_kept: got %0d want 1", RALLY); else pass_cnt++;
        tick(1);
        total_cnt++; if (FOUL !== 1'b0) $display("FAIL foul_one_cycle: got %b want 0", FOUL); else pass_cnt++;
        PULSER = 1'b0;
        tick(3);
        total_cnt++; if (foul_seen !== 1) $display("FAIL foul_count: got %0d want 1", foul_seen); else pass_cnt++;
        total_cnt++; if (SERVE_REQ !== 1'b0) $display("FAIL foul_no_state_change: got %b want 0", SERVE_REQ); else pass_cnt++;
        // Edge arrives in the very cycle the ball leaves the paddle end.
        LGOUT = 8'h40;
        tick(1);
        LGOUT = 8'h80;
        tick(1);
        clear_seen();
        PULSER = 1'b1;
        tick(2);
        LGOUT = 8'h40;
        tick(1);
        total_cnt++; if (MISS !== 1'b1) $display("FAIL late_press_miss: got %b want 1", MISS); else pass_cnt++;
        total_cnt++; if (HIT !== 1'b0) $display("FAIL late_press_no_hit: got %b want 0", HIT); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd1) $display("FAIL late_press_cnt: got %0d want 1", MISS_CNT); else pass_cnt++;
        tick(2);
        PULSER = 1'b0;
        total_cnt++; if (hit_seen !== 0) $display("FAIL late_press_hit_count: got %0d want 0", hit_seen); else pass_cnt++;
        pulse_start();
        tick(3);
    endtask

    task automatic test_restart();
        hit_window();
        hit_window();
        total_cnt++; if (RALLY !== 8'd2) $display("FAIL restart_rally_pre: got %0d want 2", RALLY); else pass_cnt++;
        LGOUT = 8'h40;
        tick(1);
        LGOUT = 8'h80;
        tick(1);
        clear_seen();
        pulse_start();
        total_cnt++; if (RALLY !== 8'd0) $display("FAIL restart_rally: got %0d want 0", RALLY); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd1) $display("FAIL restart_cnt_kept: got %0d want 1", MISS_CNT); else pass_cnt++;
        LGOUT = 8'h40;
        tick(2);
        total_cnt++; if (miss_seen !== 0) $display("FAIL restart_no_miss: got %0d want 0", miss_seen); else pass_cnt++;
        // START in the same cycle as a valid paddle edge wins.
        hit_window();
        LGOUT = 8'h40;
        tick(1);
        LGOUT = 8'h80;
        tick(1);
        clear_seen();
        PULSER = 1'b1;
        tick(2);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        total_cnt++; if (HIT !== 1'b0) $display("FAIL start_priority_hit: got %b want 0", HIT); else pass_cnt++;
        total_cnt++; if (RALLY !== 8'd0) $display("FAIL start_priority_rally: got %0d want 0", RALLY); else pass_cnt++;
        PULSER = 1'b0;
        tick(3);
        total_cnt++; if (hit_seen + foul_seen !== 0) $display("FAIL start_priority_pulses: got %0d want 0", hit_seen + foul_seen); else pass_cnt++;
    endtask

    task automatic test_pos_err();
        total_cnt++; if (POS_ERR !== 1'b0) $display("FAIL pos_err_clean: got %b want 0", POS_ERR); else pass_cnt++;
        LGOUT = 8'h81;
        tick(1);
        total_cnt++; if (POS_ERR !== 1'b1) $display("FAIL pos_err_set: got %b want 1", POS_ERR); else pass_cnt++;
        LGOUT = 8'h00;
        tick(1);
        pulse_start();
        total_cnt++; if (POS_ERR !== 1'b1) $display("FAIL pos_err_sticky: got %b want 1", POS_ERR); else pass_cnt++;
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        tick(1);
        total_cnt++; if (POS_ERR !== 1'b0) $display("FAIL pos_err_reset: got %b want 0", POS_ERR); else pass_cnt++;
    endtask

    task automatic test_rally_saturation();
        logic [7:0] exp_q[$];
        int exp_rally;
        exp_rally = 0;
        pulse_start();
        clear_seen();
        for (int k = 0; k < 300; k++) begin
            hit_window();
            exp_rally = (exp_rally == 255) ? 255 : exp_rally + 1;
            if (k == 254 || k == 299) exp_q.push_back(8'(exp_rally));
            if (k == 254) begin
                total_cnt++; if (RALLY !== exp_q.pop_front()) $display("FAIL rally_reach_255: got %0d want 255", RALLY); else pass_cnt++;
            end
        end
        total_cnt++; if (RALLY !== exp_q.pop_front()) $display("FAIL rally_saturate: got %0d want 255", RALLY); else pass_cnt++;
        total_cnt++; if (hit_seen !== 300) $display("FAIL rally_hit_count: got %0d want 300", hit_seen); else pass_cnt++;
        // Reset while a window is open and a press is in flight.
        LGOUT = 8'h40;
        tick(1);
        LGOUT = 8'h80;
        tick(1);
        PULSER = 1'b1;
        tick(1);
        RESET = 1'b1;
        tick(1);
        clear_seen();
        total_cnt++; if (HIT !== 1'b0) $display("FAIL midwin_reset_hit: got %b want 0", HIT); else pass_cnt++;
        total_cnt++; if (RALLY !== 8'd0) $display("FAIL midwin_reset_rally: got %0d want 0", RALLY); else pass_cnt++;
        total_cnt++; if (MISS_CNT !== 4'd0) $display("FAIL midwin_reset_cnt: got %0d want 0", MISS_CNT); else pass_cnt++;
        total_cnt++; if ({MISS, FOUL, SERVE_REQ, GAME_OVER, POS_ERR} !== 5'b0) $display("FAIL midwin_reset_flags: got %b want 00000", {MISS, FOUL, SERVE_REQ, GAME_OVER, POS_ERR}); else pass_cnt++;
        RESET = 1'b0;
        tick(4);
        PULSER = 1'b0;
        tick(2);
        total_cnt++; if (hit_seen + foul_seen + miss_seen !== 0) $display("FAIL idle_after_reset: got %0d pulses want 0", hit_seen + foul_seen + miss_seen); else pass_cnt++;
    endtask

    initial begin
        RESET  = 1'b1;
        START  = 1'b0;
        PULSER = 1'b0;
        LGOUT  = 8'h00;
        test_reset();
        test_hit();
        test_miss();
        test_game_over();
        test_foul_and_coincident();
        test_restart();
        test_pos_err();
        test_rally_saturation();
        total_cnt++; if (excl_viol !== 0) $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", excl_viol); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/handball_referee.md
HANDBALL_REFEREE -- requirements
Module: handball_referee

Interface
REQ-001 SHALL have parameter MAX_MISSES, default 3, meaning misses that end a game (1..15).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning stable-cycle count for paddle filter (used only with REQ-030).
REQ-003 SHALL have a single clock and a synchronous, active-high reset, named CLKK and RESET as elsewhere in the game logic.
REQ-004 SHALL have ports:
- CLKK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- START  in  1  level, new game/serve request
- PULSER  in  1  player paddle button, asynchronous level
- LGOUT  in  8  ball-position LED bus from the ball shifter; bit7 = paddle end, bit0 = wall
- HIT  out  1  one-cycle pulse, valid return
- MISS  out  1  one-cycle pulse, ball left paddle end unreturned
- FOUL  out  1  one-cycle pulse, paddle pressed outside window
- RALLY  out  8  consecutive hits in the current serve, saturating at 255
- MISS_CNT  out  4  misses this game
- SERVE_REQ  out  1  level, waiting for START after a miss
- GAME_OVER  out  1  level, MISS_CNT reached MAX_MISSES
- POS_ERR  out  1  sticky, LGOUT had more than one bit set

Function
REQ-005 SHALL implement states IDLE, PLAY, WINDOW, SERVE, OVER.
REQ-006 IDLE: START=1 -> PLAY, RALLY=0, MISS_CNT=0.
REQ-007 PLAY: LGOUT==8'h80 while armed -> WINDOW next cycle; armed clears on entry to WINDOW, sets when LGOUT!=8'h80.
REQ-008 WINDOW: paddle rising edge while LGOUT==8'h80 -> HIT=1 one cycle, RALLY+1 (saturate 255), -> PLAY.
REQ-009 WINDOW: LGOUT!=8'h80 with no paddle edge that cycle -> MISS=1 one cycle, MISS_CNT+1, RALLY=0; -> OVER if new MISS_CNT==MAX_MISSES, else -> SERVE.
REQ-010 Paddle edge in the same cycle LGOUT leaves 8'h80 SHALL count as MISS, not HIT.
REQ-011 Paddle rising edge in PLAY SHALL pulse FOUL only; no score or state change.
REQ-012 SERVE: SERVE_REQ=1; START=1 -> PLAY, SERVE_REQ=0, MISS_CNT kept.
REQ-013 OVER: GAME_OVER=1, all paddle edges ignored; START=1 -> PLAY, MISS_CNT=0, RALLY=0, GAME_OVER=0.
REQ-014 START=1 in PLAY or WINDOW SHALL restart the serve: RALLY=0, -> PLAY, MISS_CNT kept, no MISS pulse.
REQ-015 START SHALL have priority over paddle and LGOUT events in the same cycle.
REQ-016 POS_ERR SHALL set when popcount(LGOUT)>1 in any state and clear only on RESET; LGOUT==0 is legal.
REQ-017 PULSER SHALL pass through a two-flop synchronizer; edge detected on synchronized value, latency 3 cycles from pin to HIT/FOUL.
REQ-018 HIT, MISS, FOUL SHALL be mutually exclusive per cycle.

Reset
REQ-019 RESET=1 at a CLKK edge SHALL force IDLE, all outputs 0, armed=1, synchronizer and debounce state 0.
REQ-020 RESET SHALL override START and any in-progress window.

Configuration
REQ-030 With REFEREE_DEBOUNCE_EN defined, synchronized PULSER SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples (adds DEBOUNCE_CYCLES to REQ-017 latency); undefined, no filter and no DEBOUNCE_CYCLES logic.

Structure
REQ-040 Package handball_pkg SHALL hold the state enum, BALL_AT_PADDLE=8'h80, and counter widths.
REQ-041 Sub-module paddle_edge SHALL contain synchronizer, optional debounce, and rising-edge detect, outputting a one-cycle pulse.

Verification
REQ-050 RESET, START, LGOUT 01->02->...->80, press PULSER at 80 -> HIT once, RALLY=1, FOUL=0.
REQ-051 LGOUT 80->40 with no press -> MISS once, MISS_CNT=1, SERVE_REQ=1; START -> PLAY, SERVE_REQ=0.
REQ-052 Three misses with MAX_MISSES=3 -> GAME_OVER=1, further presses give no HIT/FOUL; START -> MISS_CNT=0, GAME_OVER=0.
REQ-053 Press while LGOUT=8'h08 -> FOUL once, RALLY unchanged; press edge coincident with 80->40 -> MISS, no HIT.
REQ-054 LGOUT=8'h81 one cycle -> POS_ERR=1, persists through START, clears on RESET.
REQ-055 300 consecutive hits -> RALLY=255; RESET mid-WINDOW -> IDLE, all outputs 0.
